// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command path: parser states, error codes and frame defaults.
// The I2C command engine and the TX response block import the same defaults.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GET_CMD = 3'd1,
    S_GET_ARG = 3'd2,
    S_GET_SUM = 3'd3,
    S_ISSUE   = 3'd4
  } state_e;

  localparam logic [1:0] ERR_SUM = 2'd1;
  localparam logic [1:0] ERR_TMO = 2'd2;
  localparam logic [1:0] ERR_OVR = 2'd3;

  localparam logic [7:0] DEF_HEADER  = 8'hAA;
  localparam int         DEF_TIMEOUT = 312500;
  localparam int         DEF_TW      = 19;

  function automatic logic [7:0] frame_sum(input logic [7:0] code, input logic [7:0] arg);
    return code ^ arg;
  endfunction

endpackage

// File: rtl/rx_gap_timer.sv
// Inter-byte gap counter. The count equals the number of cycles since the last accepted strobe;
// expired flags the final cycle in which a byte may still arrive.
module rx_gap_timer #(
  parameter int TIMEOUT = 312500,
  parameter int TW      = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TW-1:0] cnt_q;

  // clr loads 1: the first cycle after a strobe is already one cycle into the gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= TW'(1);
    end else if (en) begin
      cnt_q <= cnt_q + TW'(1);
    end
  end

  assign expired = en && (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame parser and command sequencer: assembles HEADER/cmd/arg/sum frames from the UART byte
// stream, enforces the inter-byte timeout and hands good commands to the I2C engine.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] HEADER  = DEF_HEADER,
  parameter int         TIMEOUT = DEF_TIMEOUT,
  parameter int         TW      = DEF_TW
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done_sig,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [7:0] cmd_arg,
  input  logic       cmd_ready,
  output logic       busy,
  output logic       err_sig,
  output logic [1:0] err_code,
  output logic [2:0] state_dbg_o
);

  // Handshake: cmd_valid rises once a frame checks out and holds with cmd_code/cmd_arg
  // stable until the cycle where cmd_valid & cmd_ready are both high; that cycle transfers it.
  state_e     state_q;
  logic       cmd_valid_q;
  logic [7:0] cmd_code_q;
  logic [7:0] cmd_arg_q;
  logic       err_sig_q;
  logic [1:0] err_code_q;

  logic in_frame;
  logic tmr_clr;
  logic tmr_expired;

  assign in_frame = (state_q == S_GET_CMD) || (state_q == S_GET_ARG) || (state_q == S_GET_SUM);
  assign tmr_clr  = rx_done_sig && (in_frame || ((state_q == S_IDLE) && (rx_data == HEADER)));

  rx_gap_timer #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (in_frame),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= 8'h00;
      cmd_arg_q   <= 8'h00;
      err_sig_q   <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      err_sig_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rx_done_sig && (rx_data == HEADER)) state_q <= S_GET_CMD;
        end
        S_GET_CMD: begin
          if (rx_done_sig) begin
            cmd_code_q <= rx_data;
            state_q    <= S_GET_ARG;
          end else if (tmr_expired) begin
            err_sig_q  <= 1'b1;
            err_code_q <= ERR_TMO;
            state_q    <= S_IDLE;
          end
        end
        S_GET_ARG: begin
          if (rx_done_sig) begin
            cmd_arg_q <= rx_data;
            state_q   <= S_GET_SUM;
          end else if (tmr_expired) begin
            err_sig_q  <= 1'b1;
            err_code_q <= ERR_TMO;
            state_q    <= S_IDLE;
          end
        end
        S_GET_SUM: begin
          if (rx_done_sig) begin
            if (rx_data == frame_sum(cmd_code_q, cmd_arg_q)) begin
              cmd_valid_q <= 1'b1;
              state_q     <= S_ISSUE;
            end else begin
              err_sig_q  <= 1'b1;
              err_code_q <= ERR_SUM;
              state_q    <= S_IDLE;
            end
          end else if (tmr_expired) begin
            err_sig_q  <= 1'b1;
            err_code_q <= ERR_TMO;
            state_q    <= S_IDLE;
          end
        end
        S_ISSUE: begin
          // Bytes arriving while a command is pending are dropped, even in the handshake cycle.
          if (rx_done_sig) begin
            err_sig_q  <= 1'b1;
            err_code_q <= ERR_OVR;
          end
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          cmd_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_code    = cmd_code_q;
  assign cmd_arg     = cmd_arg_q;
  assign busy        = (state_q != S_IDLE);
  assign err_sig     = err_sig_q;
  assign err_code    = err_code_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed scenarios plus randomized byte streams checked against a
// frame-level reference model through expected queues drained by a monitor.
module tb_uart_cmd_ctrl;
  import uart_cmd_pkg::*;

  localparam int         TIMEOUT = 16;
  localparam int         TW      = 5;
  localparam logic [7:0] HDR     = 8'hAA;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done_sig = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic [7:0] cmd_arg;
  logic       busy;
  logic       err_sig;
  logic [1:0] err_code;
  logic [2:0] state_dbg;

  logic [15:0] exp_cmd_q[$];
  logic [1:0]  exp_err_q[$];
  logic [7:0]  frame_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  uart_cmd_ctrl #(
    .HEADER  (HDR),
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_done_sig (rx_done_sig),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .cmd_arg     (cmd_arg),
    .cmd_ready   (cmd_ready),
    .busy        (busy),
    .err_sig     (err_sig),
    .err_code    (err_code),
    .state_dbg_o (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame is the header plus the next three bytes; a gap of TIMEOUT or more cycles
  // between bytes of an open frame abandons it with a timeout error.
  function automatic void model_gap(input int gap);
    if (frame_q.size() > 0 && gap >= TIMEOUT) begin
      exp_err_q.push_back(2'd2);
      frame_q.delete();
    end
  endfunction

  function automatic bit model_byte(input logic [7:0] b);
    if (frame_q.size() == 0 && b != HDR) return 1'b0;
    frame_q.push_back(b);
    if (frame_q.size() < 4) return 1'b0;
    if (frame_q[3] == (frame_q[1] ^ frame_q[2])) begin
      exp_cmd_q.push_back({frame_q[1], frame_q[2]});
      frame_q.delete();
      return 1'b1;
    end
    exp_err_q.push_back(2'd1);
    frame_q.delete();
    return 1'b0;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL cmd_unexpected: got %02h/%02h, required no command", cmd_code, cmd_arg);
        end else begin
          check("cmd_code_arg", {16'h0, cmd_code, cmd_arg}, {16'h0, exp_cmd_q.pop_front()});
        end
      end
      if (err_sig) begin
        if (exp_err_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL err_unexpected: got code %0d, required no error", err_code);
        end else begin
          check("err_code", {30'h0, err_code}, {30'h0, exp_err_q.pop_front()});
        end
      end
    end
  end

  // ---------------- drivers ----------------
  // Random ready delay after a good frame, with occasional bytes landing in the pending window.
  task automatic issue_window();
    int d;
    d = $urandom_range(0, 4);
    for (int i = 0; i <= d; i++) begin
      if (i == 0) check("valid_at_t1", {31'h0, cmd_valid}, 32'h1);
      cmd_ready = (i == d);
      if ($urandom_range(0, 3) == 0) begin
        rx_data     = 8'($urandom);
        rx_done_sig = 1'b1;
        exp_err_q.push_back(2'd3);
      end
      tick();
      rx_done_sig = 1'b0;
      cmd_ready   = 1'b0;
    end
    check("valid_after_hs", {31'h0, cmd_valid}, 32'h0);
    check("busy_after_hs", {31'h0, busy}, 32'h0);
  endtask

  // Strobe byte b exactly gap cycles after the previous strobe.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit auto_issue);
    bit issued;
    model_gap(gap);
    repeat (gap - 1) tick();
    rx_data     = b;
    rx_done_sig = 1'b1;
    issued      = model_byte(b);
    tick();
    rx_done_sig = 1'b0;
    rx_data     = 8'($urandom);
    if (issued && auto_issue) issue_window();
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] s,
                            input bit auto_issue);
    send_byte(HDR, 1, auto_issue);
    send_byte(c, 1, auto_issue);
    send_byte(a, 1, auto_issue);
    send_byte(s, 1, auto_issue);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, {31'h0, cmd_valid}, 32'h0);
    check({tag, "_code"}, {24'h0, cmd_code}, 32'h0);
    check({tag, "_arg"}, {24'h0, cmd_arg}, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_err_sig"}, {31'h0, err_sig}, 32'h0);
    check({tag, "_err_code"}, {30'h0, err_code}, 32'h0);
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values(tag);
    exp_cmd_q.delete();
    exp_err_q.delete();
    frame_q.delete();
    cmd_ready   = 1'b0;
    rx_done_sig = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic int rand_gap();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5) return $urandom_range(1, 3);
    if (r == 6) return TIMEOUT - 1;
    if (r == 7) return $urandom_range(4, TIMEOUT - 1);
    if (r == 8) return TIMEOUT;
    return TIMEOUT + $urandom_range(1, 5);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] c, a, s;
    int kind, n;

    rst_n = 1'b0;
    repeat (3) tick();
    check_reset_values("rst");
    check("rst_state", {29'h0, state_dbg}, {29'h0, S_IDLE});
    rst_n = 1'b1;
    tick();

    // Command held while ready is low, then a single-cycle handshake.
    send_frame(8'h48, 8'h00, 8'h48, 1'b0);
    check("d1_busy", {31'h0, busy}, 32'h1);
    for (int k = 0; k < 20; k++) begin
      check("d1_valid_hold", {31'h0, cmd_valid}, 32'h1);
      check("d1_code_hold", {24'h0, cmd_code}, 32'h48);
      check("d1_arg_hold", {24'h0, cmd_arg}, 32'h00);
      tick();
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check("d1_valid_drop", {31'h0, cmd_valid}, 32'h0);
    check("d1_idle", {31'h0, busy}, 32'h0);

    // Bad checksum, header accepted in the very first cycle after the handshake.
    send_frame(8'h1E, 8'h05, 8'h00, 1'b1);
    check("d2_err_pulse", {31'h0, err_sig}, 32'h1);
    check("d2_err_code", {30'h0, err_code}, 32'h1);
    check("d2_no_valid", {31'h0, cmd_valid}, 32'h0);
    tick();
    check("d2_err_1cyc", {31'h0, err_sig}, 32'h0);
    check("d2_code_held", {30'h0, err_code}, 32'h1);
    send_frame(8'hA2, 8'h00, 8'hA2, 1'b1);

    // Header followed by silence: timeout decided at t+TIMEOUT-1, strobe at t+TIMEOUT.
    send_byte(HDR, 3, 1'b1);
    model_gap(TIMEOUT);
    for (int k = 1; k <= TIMEOUT - 1; k++) begin
      check("d3_no_err_yet", {31'h0, err_sig}, 32'h0);
      if (k == TIMEOUT - 1) check("d3_busy_last", {31'h0, busy}, 32'h1);
      tick();
    end
    check("d3_tmo_pulse", {31'h0, err_sig}, 32'h1);
    check("d3_tmo_code", {30'h0, err_code}, 32'h2);
    check("d3_tmo_idle", {31'h0, busy}, 32'h0);
    tick();
    check("d3_tmo_1cyc", {31'h0, err_sig}, 32'h0);
    send_byte(HDR, 3, 1'b1);
    send_byte(8'h21, TIMEOUT - 1, 1'b1);
    send_byte(8'h03, TIMEOUT - 1, 1'b1);
    send_byte(8'h22, TIMEOUT - 1, 1'b1);

    // Leading junk is ignored silently.
    send_byte(8'h00, 2, 1'b1);
    send_byte(8'h55, 1, 1'b1);
    send_byte(8'hFF, 1, 1'b1);
    send_frame(8'h50, 8'h01, 8'h51, 1'b1);

    // Strobe in the handshake cycle: overrun, command still delivered once.
    send_frame(8'h60, 8'h0F, 8'h6F, 1'b0);
    repeat (3) tick();
    cmd_ready   = 1'b1;
    rx_data     = 8'hAA;
    rx_done_sig = 1'b1;
    exp_err_q.push_back(2'd3);
    tick();
    cmd_ready   = 1'b0;
    rx_done_sig = 1'b0;
    check("d5_ovr_pulse", {31'h0, err_sig}, 32'h1);
    check("d5_ovr_code", {30'h0, err_code}, 32'h3);
    check("d5_valid_drop", {31'h0, cmd_valid}, 32'h0);
    check("d5_idle", {31'h0, busy}, 32'h0);

    // Asynchronous reset in GET_ARG and in ISSUE.
    send_byte(HDR, 2, 1'b1);
    send_byte(8'h48, 1, 1'b1);
    tick();
    async_reset_check("rst_arg");
    send_frame(8'h77, 8'h01, 8'h76, 1'b0);
    tick();
    async_reset_check("rst_issue");
    send_frame(8'h12, 8'h34, 8'h26, 1'b1);

    // Randomized streams.
    for (int it = 0; it < 80; it++) begin
      kind = $urandom_range(0, 9);
      c = ($urandom_range(0, 7) == 0) ? HDR : 8'($urandom);
      a = ($urandom_range(0, 7) == 0) ? HDR : 8'($urandom);
      s = c ^ a;
      if (kind == 5 || kind == 6) s = s ^ 8'($urandom_range(1, 255));
      if (kind <= 6 || kind == 9) begin
        send_byte(HDR, $urandom_range(1, TIMEOUT + 4), 1'b1);
        send_byte(c, (kind == 9) ? rand_gap() : $urandom_range(1, 3), 1'b1);
        send_byte(a, (kind == 9) ? rand_gap() : $urandom_range(1, 3), 1'b1);
        send_byte(s, (kind == 9) ? rand_gap() : $urandom_range(1, 3), 1'b1);
      end else if (kind == 7) begin
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) send_byte(8'($urandom), $urandom_range(1, 6), 1'b1);
      end else begin
        send_byte(HDR, $urandom_range(1, TIMEOUT + 4), 1'b1);
        n = $urandom_range(0, 2);
        for (int j = 0; j < n; j++) send_byte(8'($urandom), $urandom_range(1, 3), 1'b1);
      end
    end

    model_gap(TIMEOUT + 5);
    repeat (TIMEOUT + 5) tick();
    check("cmd_queue_drained", exp_cmd_q.size(), 32'h0);
    check("err_queue_drained", exp_err_q.size(), 32'h0);
    check("final_idle", {31'h0, busy}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
